// File: rtl/radarpim_reset_pkg.sv
// radarpim_reset_pkg
// Shared definitions for the RadarPIM reset sequencer:
//   - state encoding (3 bits) as localparams plus the matching enum
//   - default timing constants
//   - small helpers that map a state to the reset domains it releases
package radarpim_reset_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_HOLD      = 3'd0;
  localparam logic [STATE_W-1:0] S_WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] S_STABLE    = 3'd2;
  localparam logic [STATE_W-1:0] S_REL_SYS   = 3'd3;
  localparam logic [STATE_W-1:0] S_REL_MEM   = 3'd4;
  localparam logic [STATE_W-1:0] S_REL_CORE  = 3'd5;
  localparam logic [STATE_W-1:0] S_RUN       = 3'd6;
  localparam logic [STATE_W-1:0] S_PLL_RESET = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD      = S_HOLD,
    ST_WAIT_LOCK = S_WAIT_LOCK,
    ST_STABLE    = S_STABLE,
    ST_REL_SYS   = S_REL_SYS,
    ST_REL_MEM   = S_REL_MEM,
    ST_REL_CORE  = S_REL_CORE,
    ST_RUN       = S_RUN,
    ST_PLL_RESET = S_PLL_RESET
  } state_t;

  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_STAGE_DELAY        = 16;
  localparam int DEF_WDT_CYCLES         = 65535;
  localparam int DEF_PLL_RST_CYCLES     = 8;
  localparam int DEF_CNT_WIDTH          = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Domains stay released in every later stage of the sequence, so each
  // helper covers its own release state and everything after it.
  function automatic logic sys_released(input state_t s);
    return (s == ST_REL_SYS) || (s == ST_REL_MEM) || (s == ST_REL_CORE) || (s == ST_RUN);
  endfunction

  function automatic logic mem_released(input state_t s);
    return (s == ST_REL_MEM) || (s == ST_REL_CORE) || (s == ST_RUN);
  endfunction

  function automatic logic core_released(input state_t s);
    return (s == ST_REL_CORE) || (s == ST_RUN);
  endfunction

  function automatic state_t next_release(input state_t s);
    case (s)
      ST_REL_SYS: return ST_REL_MEM;
      ST_REL_MEM: return ST_REL_CORE;
      default:    return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/radarpim_sync_2ff.sv
// radarpim_sync_2ff
// Two-flop synchronizer bringing the asynchronous PLL lock flag into the
// clk_system domain. Both flops clear on synchronous reset.
// Ports:
//   i_clk    in   clock
//   i_rstnn  in   synchronous active-low reset
//   i_async  in   asynchronous level input
//   o_sync   out  synchronized level (2-cycle latency)
module radarpim_sync_2ff (
  input  logic i_clk,
  input  logic i_rstnn,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rstnn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/radarpim_reset_sequencer.sv
// radarpim_reset_sequencer
// Releases the clk_system reset domains (system -> memory -> PIM core) once
// the PLL lock has been stable for LOCK_STABLE_CYCLES, with STAGE_DELAY cycles
// between releases. Lock loss or an accepted software request re-asserts all
// three resets together.
//
// Optional feature macro: RADARPIM_RESET_SEQ_WATCHDOG_EN
//   When defined, waiting for lock (WAIT_LOCK + STABLE) for WDT_CYCLES cycles
//   pulses pll_rst for PLL_RST_CYCLES cycles and restarts from HOLD.
//   When undefined, pll_rst is constant 0 and the wait is unbounded.
//
// Ports:
//   clk              in   system clock
//   rstnn            in   synchronous active-low reset
//   pll_locked       in   PLL lock flag (asynchronous, synchronized here)
//   sw_rst_req       in   software re-sequence request (level)
//   sw_rst_ack       out  one-cycle acceptance pulse
//   rstnn_system     out  domain 0 reset, active low
//   rstnn_memory     out  domain 1 reset, active low
//   rstnn_core       out  domain 2 reset, active low
//   seq_done         out  high only in RUN
//   seq_state        out  current FSM state (debug/observability)
//   lock_loss_count  out  saturating count of lock-loss events
//   pll_rst          out  active-high PLL reset request
//
// Handshake: sw_rst_req is a level request; it is accepted only on a cycle
// where the FSM is in RUN with lock present. Acceptance is signalled by a
// single-cycle sw_rst_ack on the following edge; the requester should drop
// the request after seeing ack (a held request re-triggers once RUN returns).
module radarpim_reset_sequencer
  import radarpim_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGE_DELAY        = DEF_STAGE_DELAY,
  parameter int CNT_WIDTH          = DEF_CNT_WIDTH,
  parameter int WDT_CYCLES         = DEF_WDT_CYCLES,
  parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic               pll_locked,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic               rstnn_system,
  output logic               rstnn_memory,
  output logic               rstnn_core,
  output logic               seq_done,
  output logic [STATE_W-1:0] seq_state,
  output logic [7:0]         lock_loss_count,
  output logic               pll_rst
);

  // The counter only ever reaches (terminal - 1) before the state exits.
  localparam int CNT_NEEDED = max2(max2(LOCK_STABLE_CYCLES, STAGE_DELAY),
                                   max2(WDT_CYCLES, PLL_RST_CYCLES));

  if (longint'(CNT_NEEDED) > (longint'(1) << CNT_WIDTH)) begin : g_cnt_width_check
    $error("CNT_WIDTH too small for the configured cycle counts");
  end

  localparam logic [CNT_WIDTH-1:0] LSC_LAST   = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAGE_LAST = CNT_WIDTH'(STAGE_DELAY - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_lk;
  logic                 w_lock_lost;
  logic                 w_sw_accept;
  logic                 w_wdt_fire;

  logic                 r_rstnn_system;
  logic                 r_rstnn_memory;
  logic                 r_rstnn_core;
  logic                 r_seq_done;
  logic                 r_sw_rst_ack;
  logic [7:0]           r_lock_loss_count;

  radarpim_sync_2ff u_lock_sync (
    .i_clk   (clk),
    .i_rstnn (rstnn),
    .i_async (pll_locked),
    .o_sync  (w_lk)
  );

`ifdef RADARPIM_RESET_SEQ_WATCHDOG_EN
  localparam logic [CNT_WIDTH-1:0] WDT_LAST    = CNT_WIDTH'(WDT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PLLRST_LAST = CNT_WIDTH'(PLL_RST_CYCLES - 1);

  // Counts total cycles spent waiting for lock, across STABLE->WAIT_LOCK
  // bounces; any other state clears it, so HOLD always starts it from zero.
  logic [CNT_WIDTH-1:0] r_wdt;
  logic                 r_pll_rst;

  assign w_wdt_fire = (r_wdt == WDT_LAST);

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      r_wdt <= '0;
    end else if ((r_state == ST_WAIT_LOCK) || (r_state == ST_STABLE)) begin
      r_wdt <= r_wdt + 1'b1;
    end else begin
      r_wdt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      r_pll_rst <= 1'b0;
    end else begin
      r_pll_rst <= (w_state_next == ST_PLL_RESET);
    end
  end

  assign pll_rst = r_pll_rst;
`else
  assign w_wdt_fire = 1'b0;
  assign pll_rst    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_lock_lost  = 1'b0;
    w_sw_accept  = 1'b0;
    case (r_state)
      ST_HOLD: begin
        w_state_next = ST_WAIT_LOCK;
        w_cnt_next   = '0;
      end
      ST_WAIT_LOCK: begin
        if (w_wdt_fire) begin
          w_state_next = ST_PLL_RESET;
          w_cnt_next   = '0;
        end else if (w_lk) begin
          w_state_next = ST_STABLE;
          w_cnt_next   = '0;
        end
      end
      ST_STABLE: begin
        // Watchdog wins over the final stable cycle: the PLL did not make it.
        if (w_wdt_fire) begin
          w_state_next = ST_PLL_RESET;
          w_cnt_next   = '0;
        end else if (!w_lk) begin
          w_state_next = ST_WAIT_LOCK;
          w_cnt_next   = '0;
        end else if (r_cnt == LSC_LAST) begin
          w_state_next = ST_REL_SYS;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_REL_SYS, ST_REL_MEM, ST_REL_CORE: begin
        if (!w_lk) begin
          w_state_next = ST_WAIT_LOCK;
          w_cnt_next   = '0;
          w_lock_lost  = 1'b1;
        end else if (r_cnt == STAGE_LAST) begin
          w_state_next = next_release(r_state);
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        // Lock loss has priority over a coincident software request.
        if (!w_lk) begin
          w_state_next = ST_WAIT_LOCK;
          w_cnt_next   = '0;
          w_lock_lost  = 1'b1;
        end else if (sw_rst_req) begin
          w_state_next = ST_HOLD;
          w_cnt_next   = '0;
          w_sw_accept  = 1'b1;
        end
      end
      ST_PLL_RESET: begin
`ifdef RADARPIM_RESET_SEQ_WATCHDOG_EN
        if (r_cnt == PLLRST_LAST) begin
          w_state_next = ST_HOLD;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
`else
        w_state_next = ST_HOLD;
        w_cnt_next   = '0;
`endif
      end
      default: begin
        w_state_next = ST_HOLD;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as seq_state; releasing follows the state order, while dropping back to
  // WAIT_LOCK or HOLD asserts all three resets at once.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      r_rstnn_system    <= 1'b0;
      r_rstnn_memory    <= 1'b0;
      r_rstnn_core      <= 1'b0;
      r_seq_done        <= 1'b0;
      r_sw_rst_ack      <= 1'b0;
      r_lock_loss_count <= 8'd0;
    end else begin
      r_rstnn_system <= sys_released(w_state_next);
      r_rstnn_memory <= mem_released(w_state_next);
      r_rstnn_core   <= core_released(w_state_next);
      r_seq_done     <= (w_state_next == ST_RUN);
      r_sw_rst_ack   <= w_sw_accept;
      if (w_lock_lost && (r_lock_loss_count != 8'hFF)) begin
        r_lock_loss_count <= r_lock_loss_count + 8'd1;
      end
    end
  end

  assign rstnn_system    = r_rstnn_system;
  assign rstnn_memory    = r_rstnn_memory;
  assign rstnn_core      = r_rstnn_core;
  assign seq_done        = r_seq_done;
  assign sw_rst_ack      = r_sw_rst_ack;
  assign lock_loss_count = r_lock_loss_count;
  assign seq_state       = r_state;

endmodule
